// File: rtl/seq_det_pkg.sv
// Shared types and default constants for the parametrised serial pattern detector.
package seq_det_pkg;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int              PAT_W_C       = 4;
  localparam logic [3:0]      DEFAULT_PAT_C = 4'b1001;
  localparam int              CNT_W_C       = 8;

  // Width of a counter holding 0..pat_w-1 valid history bits.
  function automatic int fill_width(input int pat_w);
    return (pat_w <= 2) ? 1 : $clog2(pat_w);
  endfunction

endpackage

// File: rtl/seq_shift_reg.sv
// History shift register (PAT_W-1 prior bits) plus a saturating count of valid bits held.
module seq_shift_reg
  import seq_det_pkg::*;
#(
  parameter int PAT_W  = PAT_W_C,
  parameter int FILL_W = fill_width(PAT_W_C)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              shift_i,
  input  logic              x_i,
  input  logic              clear_i,
  output logic [PAT_W-2:0]  hist_o,
  output logic [FILL_W-1:0] fill_o
);

  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  logic [PAT_W-2:0]  hist_q, hist_d, hist_shift;
  logic [FILL_W-1:0] fill_q, fill_d;

  // New bit enters at the LSB; the oldest bit falls off the MSB.
  for (genvar gi = 0; gi < PAT_W - 1; gi++) begin : g_hist
    if (gi == 0) begin : g_lsb
      assign hist_shift[gi] = x_i;
    end else begin : g_upper
      assign hist_shift[gi] = hist_q[gi-1];
    end
  end

  always_comb begin
    hist_d = shift_i ? hist_shift : hist_q;
    fill_d = fill_q;
    if (clear_i) begin
      fill_d = '0;
    end else if (shift_i && (fill_q != FILL_MAX)) begin
      fill_d = fill_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

  assign hist_o = hist_q;
  assign fill_o = fill_q;

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-loadable serial pattern detector with overlap control and registered match pulse.
// Define SEQ_DET_MATCH_COUNT_EN to add the saturating match_cnt output.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W       = PAT_W_C,
  parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(DEFAULT_PAT_C),
  parameter int               CNT_W       = CNT_W_C
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             x,
  input  logic             x_valid,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
`ifdef SEQ_DET_MATCH_COUNT_EN
  output logic             z,
  output logic [CNT_W-1:0] match_cnt
`else
  output logic             z
`endif
);

  localparam int                FILL_W    = fill_width(PAT_W);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 2);

  if (PAT_W < 2 || PAT_W > 16 || CNT_W < 1) begin : g_bad_params
    $error("seq_detector_param: illegal PAT_W or CNT_W");
  end

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pattern_q, pattern_d;
  logic             z_q, z_d;
  logic             shift, clear, match;
  logic [PAT_W-2:0] hist;
  logic [FILL_W-1:0] fill;
  logic [PAT_W-1:0] cand;

  seq_shift_reg #(
    .PAT_W  (PAT_W),
    .FILL_W (FILL_W)
  ) u_shift (
    .clock   (clock),
    .reset   (reset),
    .shift_i (shift),
    .x_i     (x),
    .clear_i (clear),
    .hist_o  (hist),
    .fill_o  (fill)
  );

  assign cand = {hist, x};

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    z_d       = 1'b0;
    shift     = 1'b0;
    clear     = 1'b0;
    match     = 1'b0;
    if (pat_load) begin
      pattern_d = pat_in;
      clear     = 1'b1;
      state_d   = FILL;
    end else if (x_valid) begin
      shift = 1'b1;
      match = (state_q == RUN) && (cand == pattern_q);
      if (match) begin
        z_d = 1'b1;
        // Non-overlapping mode demands PAT_W fresh bits before the next hit.
        if (!overlap) begin
          clear   = 1'b1;
          state_d = FILL;
        end
      end else if ((state_q == FILL) && (fill == FILL_LAST)) begin
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= FILL;
      pattern_q <= DEFAULT_PAT;
      z_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      z_q       <= z_d;
    end
  end

  assign z = z_q;

`ifdef SEQ_DET_MATCH_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (z_d && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: directed bit streams with hand-computed z pulses.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       x = 1'b0;
  logic       x_valid = 1'b0;
  logic       overlap = 1'b0;
  logic       pat_load = 1'b0;
  logic [3:0] pat_in = 4'b0000;
  logic       z;
`ifdef SEQ_DET_MATCH_COUNT_EN
  logic [1:0] match_cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic       z;
    logic [1:0] cnt;
    string      tag;
  } exp_t;

  exp_t       exp_q[$];
  logic [1:0] cnt_model = 2'd0;

  always #5 clk = ~clk;

  seq_detector_param #(
    .PAT_W       (4),
    .DEFAULT_PAT (4'b1001),
    .CNT_W       (2)
  ) dut (
    .clock     (clk),
    .reset     (reset),
    .x         (x),
    .x_valid   (x_valid),
    .overlap   (overlap),
    .pat_load  (pat_load),
    .pat_in    (pat_in),
`ifdef SEQ_DET_MATCH_COUNT_EN
    .z         (z),
    .match_cnt (match_cnt)
`else
    .z         (z)
`endif
  );

  // One cycle of stimulus; ez is the z value expected after the coming rising edge.
  task automatic step(input logic r, input logic xv, input logic xb, input logic ov,
                      input logic ld, input logic [3:0] p, input logic ez, input string tag);
    exp_t e;
    @(negedge clk);
    reset    = r;
    x_valid  = xv;
    x        = xb;
    overlap  = ov;
    pat_load = ld;
    pat_in   = p;
    if (r) cnt_model = 2'd0;
    else if (ez && cnt_model != 2'd3) cnt_model = cnt_model + 2'd1;
    e.z   = ez;
    e.cnt = cnt_model;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic run_bits(input string bits, input string zexp, input logic ov, input string tag);
    for (int i = 0; i < bits.len(); i++) begin
      step(1'b0, 1'b1, bits[i] == "1", ov, 1'b0, 4'b0000, zexp[i] == "1",
           $sformatf("%s[%0d]", tag, i));
    end
  endtask

  task automatic load(input logic [3:0] p, input logic xv, input logic xb, input string tag);
    step(1'b0, xv, xb, 1'b0, 1'b1, p, 1'b0, tag);
  endtask

  // Monitor: z is a registered output, so every edge presents a result to check.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_assert++;
        if (z !== e.z) begin
          n_fail++;
          $display("FAIL %s: z=%0b expected %0b", e.tag, z, e.z);
        end else begin
          $display("ok   %s: z=%0b", e.tag, z);
        end
`ifdef SEQ_DET_MATCH_COUNT_EN
        n_assert++;
        if (match_cnt !== e.cnt) begin
          n_fail++;
          $display("FAIL %s_cnt: match_cnt=%0d expected %0d", e.tag, match_cnt, e.cnt);
        end
`endif
      end
    end
  end

  initial begin
    // Reset held with live stream; first match needs 4 new bits.
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, "rst0");
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, "rst1");
    run_bits("1001001", "0001001", 1'b1, "ovl");

    load(4'b1001, 1'b0, 1'b0, "ld_novl");
    run_bits("1001001", "0001000", 1'b0, "novl");

    // Gaps between valid bits; x toggles while invalid and must be ignored.
    load(4'b1001, 1'b0, 1'b0, "ld_gap");
    run_bits("10", "00", 1'b1, "gap_a");
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, "gap_idle0");
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, "gap_idle1");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, "gap_idle2");
    run_bits("01", "01", 1'b1, "gap_b");

    // Load mid-stream with a valid bit that must be dropped.
    run_bits("100", "000", 1'b1, "mid_pre");
    load(4'b1111, 1'b1, 1'b1, "mid_load");
    run_bits("11111", "00011", 1'b1, "mid_post");

    // Zero history must not match an all-zero pattern early.
    load(4'b0000, 1'b0, 1'b0, "ld_zero");
    run_bits("000000", "000111", 1'b1, "zero");

    load(4'b1111, 1'b0, 1'b0, "ld_ones");
    run_bits("11111111", "00010001", 1'b0, "ones_novl");
    run_bits("11", "00", 1'b0, "pre_rst");

    // Mid-stream reset restores default pattern and clears progress.
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, "mid_rst");
    run_bits("0011001", "0000001", 1'b1, "post_rst");

    // Saturation: overlap changes only before the first match.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, "sat_rst");
    load(4'b1111, 1'b0, 1'b0, "ld_sat");
    run_bits("111", "000", 1'b0, "sat_a");
    run_bits("11111", "11111", 1'b1, "sat_b");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, "tail");

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    n_assert++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised serial bit-pattern detector; the next generation of the fixed single-pattern FSM detector.
- Pattern width is a parameter, and the pattern is runtime-loadable.
- Overlapping and non-overlapping match modes are selectable per cycle.
- Sits on a serial input stream with a valid qualifier. Emits a one-cycle registered match pulse.

Parameters:
- PAT_W, 4, pattern length in bits; legal range 2..16.
- DEFAULT_PAT, 4'b1001 (PAT_W bits), pattern loaded on reset.
- CNT_W, 8, match counter width; used only with the optional feature.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- x  in  1  serial data bit.
- x_valid  in  1  x is sampled only when high.
- overlap  in  1  1 = overlapping matches allowed; 0 = history restarts after a match.
- pat_load  in  1  load pat_in as the new pattern this cycle.
- pat_in  in  PAT_W  new pattern; MSB = oldest bit, LSB = newest bit.
- z  out  1  match pulse, registered.
- match_cnt  out  CNT_W  saturating match count; present only with SEQ_DET_MATCH_COUNT_EN.

Behaviour:
- Reset (reset=1 at posedge, priority over everything):
  - pattern<=DEFAULT_PAT, hist<=0, fill<=0, state<=FILL.
  - z<=0, match_cnt<=0.
- Internal state:
  - hist: PAT_W-1 bits of prior history.
  - fill: count of valid bits held, 0..PAT_W-1.
  - FSM: FILL (fill<PAT_W-1) and RUN (fill==PAT_W-1).
- Priority per cycle: reset > pat_load > x_valid.
- pat_load=1:
  - pattern<=pat_in, fill<=0, state<=FILL, z<=0.
  - x is discarded that cycle even if x_valid=1.
- x_valid=1, no load:
  - cand = {hist, x}, PAT_W bits.
  - hist <= cand[PAT_W-2:0].
  - Match when state==RUN and cand==pattern.
- On a match:
  - z<=1 on the next edge, i.e. asserted the cycle after the last pattern bit is sampled; latency 1.
  - overlap=1: fill stays at PAT_W-1; state stays RUN.
  - overlap=0: fill<=0, state<=FILL, so PAT_W fresh bits are needed before the next match.
- No match: z<=0. In FILL, fill increments; on reaching PAT_W-1, state<=RUN.
- x_valid=0: hist, fill and state hold; z<=0. Gaps between valid bits do not break a match.
- Pulse width: z is always a single-cycle pulse; consecutive matches give back-to-back pulses (overlap=1, pattern all-ones or all-zeros).
- overlap is sampled only in the match cycle; changing it mid-stream affects only future matches.
- Startup: no match is possible until PAT_W valid bits have been received since reset/load; stale or zero history never matches.
- Reset mid-stream clears all progress; the first post-reset match still needs PAT_W bits.

Optional Feature:
- Macro: SEQ_DET_MATCH_COUNT_EN.
- Defined:
  - match_cnt port exists.
  - Increments by 1 on every cycle z is set.
  - Saturates at 2^CNT_W-1.
  - Cleared by reset only; pat_load does not clear it.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package seq_det_pkg:
  - state enum {FILL, RUN}.
  - Constants: default PAT_W=4, DEFAULT_PAT=4'b1001, CNT_W=8.
- Sub-module seq_shift_reg (history register plus fill counter, with load/clear/shift controls). The top level holds the FSM, comparator, z register and optional counter.

Test Plan:
- Reset: hold reset for 2 cycles with x_valid=1, x=1 -> z=0, match_cnt=0; first match requires 4 new bits.
- Overlap on, pattern 1001, stream 1,0,0,1,0,0,1 -> z pulses for one cycle after bits 4 and 7; match_cnt=2.
- Overlap off, same stream -> single z pulse after bit 4 only; match_cnt=1.
- Gaps: stream 1,0,0,1 with x_valid=0 for 3 cycles between bits 2 and 3 -> exactly one z pulse, one cycle after bit 4 is sampled.
- Load mid-stream:
  - Send 1,0,0, then pat_load with pat_in=4'b1111 and x_valid=1, x=1 -> no z; that bit is dropped.
  - Then 1,1,1,1,1 with overlap=1 -> z pulses after bits 4 and 5.
- Saturation (CNT_W=2, pattern 1111, overlap=1, 8 consecutive ones) -> z pulses on 5 consecutive cycles; match_cnt stops at 3.
